reg_bank_fs: RTL and testbench
==============================

Name: reg_bank_fs

Overview:
- Parametrised bank of NREGS general-purpose registers, each WIDTH bits.
- One shared function select drives the bank; a per-register enable mask chooses which registers update.
- Functions: clear, load, increment, decrement, logical shifts and rotates, with per-register carry and zero flags.
- Two independent combinational read ports; this block is the storage and counter element for the datapath register file and address registers.

Parameters:
- WIDTH, 8, data width of each register (>= 2).
- ADDR_W, 2, read-address width; NREGS = 2**ADDR_W registers.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- fun_sel  input  3  operation applied to every enabled register
- wr_en  input  NREGS  per-register enable mask; bit i selects register i
- data_in  input  WIDTH  load data
- rd_addr_a  input  ADDR_W  read port A register index
- rd_addr_b  input  ADDR_W  read port B register index
- data_out_a  output  WIDTH  contents of register rd_addr_a
- data_out_b  output  WIDTH  contents of register rd_addr_b
- flag_c_a  output  1  carry flag of register rd_addr_a
- flag_z_a  output  1  zero flag of register rd_addr_a

Behaviour:
- Reset: rst_n low forces, immediately and without waiting for clk, all registers to 0, all C flags to 0 and all Z flags to 1.
  - Output values in reset: data_out_a = data_out_b = 0, flag_c_a = 0, flag_z_a = 1.
  - Reset asserted mid-operation overrides any pending update.
  - On deassertion, the first update occurs at the next rising clk edge with rst_n high.
- Update: on each rising clk edge, every register i with wr_en[i] = 1 applies fun_sel. Registers with wr_en[i] = 0 hold their value and flags.
- fun_sel encodings:
  - 000 clear: R = 0, C = 0.
  - 001 load: R = data_in, C = 0.
  - 010 decrement: R = R - 1 modulo 2^WIDTH; C = 1 only when R was 0 (borrow, wraps to all-ones).
  - 011 increment: R = R + 1 modulo 2^WIDTH; C = 1 only when R was all-ones (wraps to 0).
  - 100 shift left logical: C = old MSB; R = {R[WIDTH-2:0], 0}.
  - 101 shift right logical: C = old LSB; R = {0, R[WIDTH-1:1]}.
  - 110 rotate left: old MSB goes to bit 0 and to C.
  - 111 rotate right: old LSB goes to the MSB and to C.
- Z flag: after every enabled update, Z = 1 iff the new R == 0. Both C and Z are registered alongside R.
- Multiple enable bits: all selected registers perform the same operation in parallel, each on its own value. There is no cross-register carry.
- wr_en = 0: a full hold, regardless of fun_sel.
- Reads: data_out_a/b and flags are purely combinational from the register state.
  - Zero read latency; an address change is reflected in the same cycle.
  - Reading a register being written returns the pre-edge value until the edge, then the new value.
  - rd_addr_a == rd_addr_b is legal; both ports show identical data.
- Write-to-read latency: 1 clk edge.
- Only data_in, fun_sel and wr_en are sampled. No X propagation from unused inputs.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with wr_en = 4'b1111, fun_sel = 001, data_in = 8'hAA -> all registers read 0, flag_z_a = 1, flag_c_a = 0. Then release rst_n, and a load at the next edge gives 8'hAA.
- Load/parallel: wr_en = 4'b0101, fun_sel = 001, data_in = 8'h3C -> R0 = R2 = 8'h3C, R1 = R3 = 0. A read on both ports at addresses 0 and 1 returns 8'h3C and 8'h00 the same cycle.
- Wrap-around:
  - Load R1 = 8'hFF, increment -> R1 = 8'h00, C = 1, Z = 1.
  - Decrement -> R1 = 8'hFF, C = 1, Z = 0.
  - Decrement -> R1 = 8'hFE, C = 0.
- Shift/rotate on R3 = 8'b1000_0001:
  - SHL -> 8'b0000_0010, C = 1.
  - SHR -> 8'b0000_0001, C = 0.
  - ROR -> 8'b1000_0000, C = 1.
  - ROL -> 8'b0000_0001, C = 1.
- Hold: wr_en = 0 with fun_sel = 000 for 3 cycles -> all values and flags unchanged.
- Async reset mid-run: increment R0 continuously from 0, then pull rst_n low between clock edges at count 5 -> R0 reads 0 before the next edge and remains 0 while rst_n is low.

Source files
------------

// File: rtl/reg_bank_fs_if.sv
// -----------------------------------------------------------------------------
// reg_bank_fs_if
//   Bus bundle for the reg_bank_fs register bank.
//
//   Command side (master -> slave):
//     fun_sel    [2:0]        operation applied to every enabled register
//     wr_en      [NREGS-1:0]  per-register update enable, bit i = register i
//     data_in    [WIDTH-1:0]  load data
//     rd_addr_a  [ADDR_W-1:0] read port A index
//     rd_addr_b  [ADDR_W-1:0] read port B index
//   Read side (slave -> master):
//     data_out_a [WIDTH-1:0]  contents of register rd_addr_a
//     data_out_b [WIDTH-1:0]  contents of register rd_addr_b
//     flag_c_a                carry flag of register rd_addr_a
//     flag_z_a                zero flag of register rd_addr_a
//
//   Handshake: there is no valid/ready pair. A write command is a single-cycle
//   transfer qualified only by wr_en, sampled on every rising clk edge, and it
//   can never be stalled. Reads are combinational and always valid.
// -----------------------------------------------------------------------------
interface reg_bank_fs_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) ();
  localparam int NREGS = 2 ** ADDR_W;

  logic [2:0]        fun_sel;
  logic [NREGS-1:0]  wr_en;
  logic [WIDTH-1:0]  data_in;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  data_out_a;
  logic [WIDTH-1:0]  data_out_b;
  logic              flag_c_a;
  logic              flag_z_a;

  modport master (
    output fun_sel, wr_en, data_in, rd_addr_a, rd_addr_b,
    input  data_out_a, data_out_b, flag_c_a, flag_z_a
  );

  modport slave (
    input  fun_sel, wr_en, data_in, rd_addr_a, rd_addr_b,
    output data_out_a, data_out_b, flag_c_a, flag_z_a
  );
endinterface

// File: rtl/reg_bank_fs.sv
// -----------------------------------------------------------------------------
// reg_bank_fs
//   Bank of NREGS = 2**ADDR_W registers, WIDTH bits each, with a per-register
//   carry (C) and zero (Z) flag. One shared fun_sel is applied in parallel to
//   every register whose wr_en bit is set; the others hold. Two combinational
//   read ports expose register contents; port A also exposes the flags.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (regs = 0, C = 0, Z = 1)
//     bus    reg_bank_fs_if.slave (command inputs, read-port outputs)
//
//   fun_sel: 000 clear, 001 load, 010 dec, 011 inc,
//            100 shl, 101 shr, 110 rol, 111 ror
//
//   The block has no FSM; its entire state is the register array and the two
//   flag vectors, all visible through the read ports.
// -----------------------------------------------------------------------------
module reg_bank_fs #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_bank_fs_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_W;

  localparam logic [2:0] FUN_CLR  = 3'b000;
  localparam logic [2:0] FUN_LOAD = 3'b001;
  localparam logic [2:0] FUN_DEC  = 3'b010;
  localparam logic [2:0] FUN_INC  = 3'b011;
  localparam logic [2:0] FUN_SHL  = 3'b100;
  localparam logic [2:0] FUN_SHR  = 3'b101;
  localparam logic [2:0] FUN_ROL  = 3'b110;
  localparam logic [2:0] FUN_ROR  = 3'b111;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Register state
  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] c_q;
  logic [NREGS-1:0] z_q;

  // Next-state candidates, computed for every register regardless of wr_en;
  // wr_en only decides whether they are captured.
  logic [WIDTH-1:0] nxt_r [NREGS];
  logic [NREGS-1:0] nxt_c;

  // Result packed as {carry, value}.
  function automatic logic [WIDTH:0] apply_fun(
    input logic [2:0]       fun,
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] din
  );
    logic [WIDTH-1:0] n;
    logic             c;
    n = r;
    c = 1'b0;
    case (fun)
      FUN_CLR: begin
        n = '0;
        c = 1'b0;
      end
      FUN_LOAD: begin
        n = din;
        c = 1'b0;
      end
      FUN_DEC: begin
        // Borrow only when wrapping 0 -> all-ones.
        n = r - ONE;
        c = (r == '0);
      end
      FUN_INC: begin
        // Carry only when wrapping all-ones -> 0.
        n = r + ONE;
        c = &r;
      end
      FUN_SHL: begin
        n = {r[WIDTH-2:0], 1'b0};
        c = r[WIDTH-1];
      end
      FUN_SHR: begin
        n = {1'b0, r[WIDTH-1:1]};
        c = r[0];
      end
      FUN_ROL: begin
        n = {r[WIDTH-2:0], r[WIDTH-1]};
        c = r[WIDTH-1];
      end
      FUN_ROR: begin
        n = {r[0], r[WIDTH-1:1]};
        c = r[0];
      end
      default: begin
        n = r;
        c = 1'b0;
      end
    endcase
    return {c, n};
  endfunction

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      nxt_r[i] = '0;
      nxt_c[i] = 1'b0;
    end
    for (int i = 0; i < NREGS; i++) begin
      {nxt_c[i], nxt_r[i]} = apply_fun(bus.fun_sel, regs[i], bus.data_in);
    end
  end

  // Storage. Z is derived from the new value and registered with it, so the
  // read side never has to compare against zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      c_q <= '0;
      z_q <= '1;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (bus.wr_en[i]) begin
          regs[i] <= nxt_r[i];
          c_q[i]  <= nxt_c[i];
          z_q[i]  <= (nxt_r[i] == '0);
        end
      end
    end
  end

  // Combinational read ports: zero latency, pre-edge value until the edge.
  assign bus.data_out_a = regs[bus.rd_addr_a];
  assign bus.data_out_b = regs[bus.rd_addr_b];
  assign bus.flag_c_a   = c_q[bus.rd_addr_a];
  assign bus.flag_z_a   = z_q[bus.rd_addr_a];

endmodule

// File: tb/tb_reg_bank_fs.sv
// -----------------------------------------------------------------------------
// tb_reg_bank_fs
//   Directed bench for reg_bank_fs (WIDTH = 8, ADDR_W = 2). Inputs change on
//   the falling edge; outputs are read away from the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_bank_fs;
  localparam int WIDTH  = 8;
  localparam int ADDR_W = 2;

  localparam logic [2:0] F_CLR  = 3'b000;
  localparam logic [2:0] F_LOAD = 3'b001;
  localparam logic [2:0] F_DEC  = 3'b010;
  localparam logic [2:0] F_INC  = 3'b011;
  localparam logic [2:0] F_SHL  = 3'b100;
  localparam logic [2:0] F_SHR  = 3'b101;
  localparam logic [2:0] F_ROL  = 3'b110;
  localparam logic [2:0] F_ROR  = 3'b111;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  reg_bank_fs_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  reg_bank_fs #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests;
  int n_fail;
  logic [WIDTH-1:0] exp_q[$];

  // ---------------- driver tasks ----------------
  // One enabled operation at the next rising edge, then back to hold.
  task automatic apply_op(input logic [2:0] fun, input logic [3:0] mask,
                          input logic [WIDTH-1:0] din);
    @(negedge clk);
    bus.fun_sel = fun;
    bus.wr_en   = mask;
    bus.data_in = din;
    @(negedge clk);
    bus.wr_en   = 4'b0000;
  endtask

  task automatic set_rd(input logic [1:0] a, input logic [1:0] b);
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n       = 1'b0;
    bus.wr_en   = 4'b1111;
    bus.fun_sel = F_LOAD;
    bus.data_in = 8'hAA;
    bus.rd_addr_a = 2'd0;
    bus.rd_addr_b = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < 4; r++) begin
      set_rd(r[1:0], r[1:0]);
      n_tests++;
      if (bus.data_out_a !== 8'h00 || bus.data_out_b !== 8'h00 ||
          bus.flag_z_a !== 1'b1 || bus.flag_c_a !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_r%0d: got a=%h b=%h z=%b c=%b, expected a=00 b=00 z=1 c=0",
                 r, bus.data_out_a, bus.data_out_b, bus.flag_z_a, bus.flag_c_a);
      end
    end
    // Release; load AA (still driven) happens at the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.wr_en = 4'b0000;
    set_rd(2'd0, 2'd3);
    n_tests++;
    if (bus.data_out_a !== 8'hAA || bus.data_out_b !== 8'hAA || bus.flag_z_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_load: got a=%h b=%h z=%b, expected a=aa b=aa z=0",
               bus.data_out_a, bus.data_out_b, bus.flag_z_a);
    end
  endtask

  task automatic test_load_parallel();
    logic [WIDTH-1:0] exp_v [4];
    exp_v[0] = 8'h3C; exp_v[1] = 8'h00; exp_v[2] = 8'h3C; exp_v[3] = 8'h00;
    apply_op(F_CLR, 4'b1111, 8'h00);
    apply_op(F_LOAD, 4'b0101, 8'h3C);
    for (int r = 0; r < 4; r++) begin
      set_rd(r[1:0], 2'd0);
      n_tests++;
      if (bus.data_out_a !== exp_v[r] || bus.flag_z_a !== (exp_v[r] == 8'h00)) begin
        n_fail++;
        $display("FAIL load_par_r%0d: got %h z=%b, expected %h z=%b",
                 r, bus.data_out_a, bus.flag_z_a, exp_v[r], (exp_v[r] == 8'h00));
      end
    end
    set_rd(2'd0, 2'd1);
    n_tests++;
    if (bus.data_out_a !== 8'h3C || bus.data_out_b !== 8'h00) begin
      n_fail++;
      $display("FAIL dual_read: got a=%h b=%h, expected a=3c b=00",
               bus.data_out_a, bus.data_out_b);
    end
  endtask

  task automatic test_wrap();
    apply_op(F_LOAD, 4'b0010, 8'hFF);
    apply_op(F_INC, 4'b0010, 8'h00);
    set_rd(2'd1, 2'd0);
    n_tests++;
    if (bus.data_out_a !== 8'h00 || bus.flag_c_a !== 1'b1 || bus.flag_z_a !== 1'b1) begin
      n_fail++;
      $display("FAIL inc_wrap: got %h c=%b z=%b, expected 00 c=1 z=1",
               bus.data_out_a, bus.flag_c_a, bus.flag_z_a);
    end
    apply_op(F_DEC, 4'b0010, 8'h00);
    n_tests++;
    if (bus.data_out_a !== 8'hFF || bus.flag_c_a !== 1'b1 || bus.flag_z_a !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_wrap: got %h c=%b z=%b, expected ff c=1 z=0",
               bus.data_out_a, bus.flag_c_a, bus.flag_z_a);
    end
    apply_op(F_DEC, 4'b0010, 8'h00);
    n_tests++;
    if (bus.data_out_a !== 8'hFE || bus.flag_c_a !== 1'b0 || bus.flag_z_a !== 1'b0) begin
      n_fail++;
      $display("FAIL dec_plain: got %h c=%b z=%b, expected fe c=0 z=0",
               bus.data_out_a, bus.flag_c_a, bus.flag_z_a);
    end
    // Neighbour untouched by R1 activity.
    n_tests++;
    if (bus.data_out_b !== 8'h3C) begin
      n_fail++;
      $display("FAIL wrap_isolation_r0: got %h, expected 3c", bus.data_out_b);
    end
  endtask

  task automatic test_shift_rotate();
    logic [2:0]       fun_v [4];
    logic [WIDTH-1:0] exp_v [4];
    logic             exp_c [4];
    fun_v[0] = F_SHL; exp_v[0] = 8'b0000_0010; exp_c[0] = 1'b1;
    fun_v[1] = F_SHR; exp_v[1] = 8'b0000_0001; exp_c[1] = 1'b0;
    fun_v[2] = F_ROR; exp_v[2] = 8'b1000_0000; exp_c[2] = 1'b1;
    fun_v[3] = F_ROL; exp_v[3] = 8'b0000_0001; exp_c[3] = 1'b1;
    apply_op(F_LOAD, 4'b1000, 8'b1000_0001);
    set_rd(2'd3, 2'd3);
    for (int k = 0; k < 4; k++) begin
      apply_op(fun_v[k], 4'b1000, 8'h00);
      n_tests++;
      if (bus.data_out_a !== exp_v[k] || bus.flag_c_a !== exp_c[k] || bus.flag_z_a !== 1'b0) begin
        n_fail++;
        $display("FAIL shift_rot_step%0d: got %b c=%b z=%b, expected %b c=%b z=0",
                 k, bus.data_out_a, bus.flag_c_a, bus.flag_z_a, exp_v[k], exp_c[k]);
      end
    end
    // Shift left of a lone MSB empties the register: Z must rise, C = 1.
    apply_op(F_LOAD, 4'b1000, 8'h80);
    apply_op(F_SHL, 4'b1000, 8'h00);
    n_tests++;
    if (bus.data_out_a !== 8'h00 || bus.flag_c_a !== 1'b1 || bus.flag_z_a !== 1'b1) begin
      n_fail++;
      $display("FAIL shl_to_zero: got %h c=%b z=%b, expected 00 c=1 z=1",
               bus.data_out_a, bus.flag_c_a, bus.flag_z_a);
    end
    apply_op(F_LOAD, 4'b1000, 8'h01);
  endtask

  task automatic test_hold();
    logic [WIDTH-1:0] exp_v [4];
    logic             exp_c [4];
    // R3 reloaded with 01 (C cleared by load).
    exp_v[0] = 8'h3C; exp_c[0] = 1'b0;
    exp_v[1] = 8'hFE; exp_c[1] = 1'b0;
    exp_v[2] = 8'h3C; exp_c[2] = 1'b0;
    exp_v[3] = 8'h01; exp_c[3] = 1'b0;
    @(negedge clk);
    bus.fun_sel = F_CLR;
    bus.wr_en   = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      set_rd(r[1:0], r[1:0]);
      n_tests++;
      if (bus.data_out_a !== exp_v[r] || bus.data_out_b !== exp_v[r] ||
          bus.flag_c_a !== exp_c[r] || bus.flag_z_a !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_r%0d: got a=%h b=%h c=%b z=%b, expected %h c=%b z=0",
                 r, bus.data_out_a, bus.data_out_b, bus.flag_c_a, bus.flag_z_a,
                 exp_v[r], exp_c[r]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [WIDTH-1:0] exp;
    apply_op(F_CLR, 4'b0001, 8'h00);
    set_rd(2'd0, 2'd3);
    @(negedge clk);
    bus.fun_sel = F_INC;
    bus.wr_en   = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(k[WIDTH-1:0]);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      n_tests++;
      if (bus.data_out_a !== exp) begin
        n_fail++;
        $display("FAIL inc_count_%0d: got %h, expected %h", k, bus.data_out_a, exp);
      end
    end
    // Mid-cycle, with an increment still pending.
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.data_out_a !== 8'h00 || bus.data_out_b !== 8'h00 ||
        bus.flag_z_a !== 1'b1 || bus.flag_c_a !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_immediate: got a=%h b=%h z=%b c=%b, expected 00 00 z=1 c=0",
               bus.data_out_a, bus.data_out_b, bus.flag_z_a, bus.flag_c_a);
    end
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.data_out_a !== 8'h00 || bus.flag_z_a !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_held: got %h z=%b, expected 00 z=1",
               bus.data_out_a, bus.flag_z_a);
    end
    @(negedge clk);
    bus.wr_en = 4'b0000;
    rst_n     = 1'b1;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_load_parallel();
    test_wrap();
    test_shift_rotate();
    test_hold();
    test_async_reset();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
